// File: rtl/id_pkg.sv
// Shared decode definitions: opcodes, ALU command encodings, branch classes and the control bundle.
package id_pkg;

  localparam int OPC_W = 6;
  localparam int CMD_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'd32;
  localparam logic [OPC_W-1:0] OP_LD   = 6'd36;
  localparam logic [OPC_W-1:0] OP_ST   = 6'd37;
  localparam logic [OPC_W-1:0] OP_BEZ  = 6'd40;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'd41;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'd42;

  localparam logic [CMD_W-1:0] EXE_NOP = 4'd0;
  localparam logic [CMD_W-1:0] EXE_ADD = 4'd1;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_class_e;

  typedef struct packed {
    logic [CMD_W-1:0] exe_cmd;
    logic             wb_en;
    logic             mem_read_en;
    logic             mem_write_en;
    logic             is_imm;
    logic             uses_rs;
    logic             uses_rt;
    br_class_e        br;
  } dec_t;

  function automatic logic is_branch(input br_class_e b);
    return b != BR_NONE;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Opcode to control table, purely combinational; unknown opcodes decode as a NOP with nothing enabled.
module id_decoder
  import id_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output dec_t             ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD: begin
        ctrl.exe_cmd = EXE_ADD;
        ctrl.wb_en   = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_ADDI: begin
        ctrl.exe_cmd = EXE_ADD;
        ctrl.wb_en   = 1'b1;
        ctrl.is_imm  = 1'b1;
        ctrl.uses_rs = 1'b1;
      end
      OP_LD: begin
        ctrl.exe_cmd     = EXE_ADD;
        ctrl.wb_en       = 1'b1;
        ctrl.mem_read_en = 1'b1;
        ctrl.is_imm      = 1'b1;
        ctrl.uses_rs     = 1'b1;
      end
      OP_ST: begin
        ctrl.exe_cmd      = EXE_ADD;
        ctrl.mem_write_en = 1'b1;
        ctrl.is_imm       = 1'b1;
        ctrl.uses_rs      = 1'b1;
        ctrl.uses_rt      = 1'b1;
      end
      // Branch offsets live in the immediate field; target arithmetic happens outside this stage.
      OP_BEZ: begin
        ctrl.is_imm  = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.br      = BR_BEZ;
      end
      OP_BNE: begin
        ctrl.is_imm  = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
        ctrl.br      = BR_BNE;
      end
      OP_JMP: begin
        ctrl.is_imm = 1'b1;
        ctrl.br     = BR_JMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_hazard.sv
// Decode stage with ID/EXE register, in-ID branch resolution and load/branch bubble sequencing.
// `ID_HAZARD_UNIT_EN enables the internal detection and stall counter; otherwise only hazard_detected_in stalls.
module id_stage_hazard
  import id_pkg::*;
#(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int EXE_CMD_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_LEN-1:0]     instruction,
  input  logic                    instr_valid,
  input  logic [WORD_LEN-1:0]     rs_value,
  input  logic [WORD_LEN-1:0]     rt_value,
  input  logic                    hazard_detected_in,
  input  logic                    freeze,
  output logic [REG_ADDR_LEN-1:0] rs,
  output logic [REG_ADDR_LEN-1:0] rt,
  output logic                    branch_taken,
  output logic                    stall_out,
  output logic                    ex_valid,
  output logic                    ex_wb_en,
  output logic                    ex_mem_read_en,
  output logic                    ex_mem_write_en,
  output logic                    ex_is_imm,
  output logic [EXE_CMD_LEN-1:0]  ex_exe_cmd,
  output logic [WORD_LEN-1:0]     ex_alu_in1,
  output logic [WORD_LEN-1:0]     ex_alu_in2,
  output logic [WORD_LEN-1:0]     ex_st_value,
  output logic [REG_ADDR_LEN-1:0] ex_dest,
  output logic [REG_ADDR_LEN-1:0] ex_rs,
  output logic [REG_ADDR_LEN-1:0] ex_rt
);

  dec_t                    ctrl;
  logic [WORD_LEN-1:0]     imm_ext;
  logic [REG_ADDR_LEN-1:0] dest;
  logic                    br_cond;

  id_decoder u_decoder (
    .opcode (instruction[31:26]),
    .ctrl   (ctrl)
  );

  assign rs      = instruction[25:21];
  assign rt      = instruction[20:16];
  assign imm_ext = {{(WORD_LEN-16){instruction[15]}}, instruction[15:0]};
  assign dest    = ctrl.is_imm ? instruction[20:16] : instruction[15:11];

  always_comb begin
    br_cond = 1'b0;
    case (ctrl.br)
      BR_BEZ:  br_cond = (rs_value == '0);
      BR_BNE:  br_cond = (rs_value != rt_value);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

`ifdef ID_HAZARD_UNIT_EN
  logic [1:0] stall_cnt;
  logic [1:0] need;
  logic       ex_producer;
  logic       src_match;
  logic       detect;

  // Non-branch consumers get ALU results forwarded in EXE; only loads cost them a bubble.
  always_comb begin
    ex_producer = ex_valid & ex_wb_en & (ex_dest != '0);
    src_match   = (ctrl.uses_rs && (rs == ex_dest)) || (ctrl.uses_rt && (rt == ex_dest));
    need        = 2'd0;
    if (instr_valid && ex_producer && src_match) begin
      if (is_branch(ctrl.br)) need = ex_mem_read_en ? 2'd2 : 2'd1;
      else if (ex_mem_read_en) need = 2'd1;
    end
    detect    = (stall_cnt == 2'd0) && (need != 2'd0);
    stall_out = detect | (stall_cnt > 2'd1) | hazard_detected_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 2'd0;
    end else if (!freeze) begin
      if (stall_cnt != 2'd0) stall_cnt <= stall_cnt - 2'd1;
      else if (detect)       stall_cnt <= need;
    end
  end
`else
  logic unused_uses;
  assign unused_uses = ctrl.uses_rs ^ ctrl.uses_rt;
  assign stall_out   = hazard_detected_in;
`endif

  assign branch_taken = br_cond & instr_valid & ~stall_out & ~freeze;

  always_ff @(posedge clk) begin
    if (rst || (!freeze && stall_out)) begin
      ex_valid        <= 1'b0;
      ex_wb_en        <= 1'b0;
      ex_mem_read_en  <= 1'b0;
      ex_mem_write_en <= 1'b0;
      ex_is_imm       <= 1'b0;
      ex_exe_cmd      <= '0;
      ex_alu_in1      <= '0;
      ex_alu_in2      <= '0;
      ex_st_value     <= '0;
      ex_dest         <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
    end else if (!freeze) begin
      ex_valid        <= instr_valid;
      ex_wb_en        <= ctrl.wb_en & instr_valid;
      ex_mem_read_en  <= ctrl.mem_read_en & instr_valid;
      ex_mem_write_en <= ctrl.mem_write_en & instr_valid;
      ex_is_imm       <= ctrl.is_imm;
      ex_exe_cmd      <= EXE_CMD_LEN'(ctrl.exe_cmd);
      ex_alu_in1      <= rs_value;
      ex_alu_in2      <= ctrl.is_imm ? imm_ext : rt_value;
      ex_st_value     <= rt_value;
      ex_dest         <= dest;
      ex_rs           <= rs;
      ex_rt           <= rt;
    end
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Randomised bench for id_stage_hazard against a bubble-owing reference model, plus directed scenarios.
module tb_id_stage_hazard;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst, instr_valid, hazard_detected_in, freeze;
  logic [31:0] instruction, rs_value, rt_value;
  logic [4:0]  rs, rt, ex_dest, ex_rs, ex_rt;
  logic        branch_taken, stall_out;
  logic        ex_valid, ex_wb_en, ex_mem_read_en, ex_mem_write_en, ex_is_imm;
  logic [3:0]  ex_exe_cmd;
  logic [31:0] ex_alu_in1, ex_alu_in2, ex_st_value;

  always #5 clk = ~clk;

  id_stage_hazard dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .rs_value(rs_value), .rt_value(rt_value), .hazard_detected_in(hazard_detected_in),
    .freeze(freeze), .rs(rs), .rt(rt), .branch_taken(branch_taken), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_read_en(ex_mem_read_en),
    .ex_mem_write_en(ex_mem_write_en), .ex_is_imm(ex_is_imm), .ex_exe_cmd(ex_exe_cmd),
    .ex_alu_in1(ex_alu_in1), .ex_alu_in2(ex_alu_in2), .ex_st_value(ex_st_value),
    .ex_dest(ex_dest), .ex_rs(ex_rs), .ex_rt(ex_rt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit        valid, wb, mr, mw, imm;
    bit [3:0]  cmd;
    bit [31:0] in1, in2, st;
    bit [4:0]  dest, rs, rt;
  } ex_m_t;

  ex_m_t m_ex;
  int    owed;       // bubbles still owed after the one issued this cycle
  bit    obs_stall, obs_branch;

  function automatic ex_m_t model_issue(input logic [31:0] ins, input bit v,
                                        input logic [31:0] a, input logic [31:0] b);
    ex_m_t      e;
    logic [5:0] op;
    bit         im;
    e  = '{default: 0};
    op = ins[31:26];
    im = op inside {OP_ADDI, OP_LD, OP_ST, OP_BEZ, OP_BNE, OP_JMP};
    e.valid = v;
    e.imm   = im;
    e.wb    = v && (op inside {OP_ADD, OP_ADDI, OP_LD});
    e.mr    = v && (op == OP_LD);
    e.mw    = v && (op == OP_ST);
    e.cmd   = (op inside {OP_ADD, OP_ADDI, OP_LD, OP_ST}) ? EXE_ADD : EXE_NOP;
    e.in1   = a;
    e.in2   = im ? {{16{ins[15]}}, ins[15:0]} : b;
    e.st    = b;
    e.dest  = im ? ins[20:16] : ins[15:11];
    e.rs    = ins[25:21];
    e.rt    = ins[20:16];
    return e;
  endfunction

  function automatic int bubbles_needed(input logic [31:0] ins, input bit v);
`ifdef ID_HAZARD_UNIT_EN
    logic [5:0] op;
    bit         hit;
    op = ins[31:26];
    if (!v || !m_ex.valid || !m_ex.wb || m_ex.dest == 0) return 0;
    hit = ((op inside {OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_BEZ, OP_BNE}) && ins[25:21] == m_ex.dest) ||
          ((op inside {OP_ADD, OP_ST, OP_BNE}) && ins[20:16] == m_ex.dest);
    if (!hit) return 0;
    if (op inside {OP_BEZ, OP_BNE}) return m_ex.mr ? 2 : 1;
    return m_ex.mr ? 1 : 0;
`else
    return (ins === 32'hx && v) ? 1 : 0;
`endif
  endfunction

  task automatic check_ex();
    check("ex_valid", ex_valid, m_ex.valid);
    check("ex_wb_en", ex_wb_en, m_ex.wb);
    check("ex_mem_read_en", ex_mem_read_en, m_ex.mr);
    check("ex_mem_write_en", ex_mem_write_en, m_ex.mw);
    check("ex_is_imm", ex_is_imm, m_ex.imm);
    check("ex_exe_cmd", ex_exe_cmd, m_ex.cmd);
    check("ex_alu_in1", ex_alu_in1, m_ex.in1);
    check("ex_alu_in2", ex_alu_in2, m_ex.in2);
    check("ex_st_value", ex_st_value, m_ex.st);
    check("ex_dest", ex_dest, m_ex.dest);
    check("ex_rs", ex_rs, m_ex.rs);
    check("ex_rt", ex_rt, m_ex.rt);
  endtask

  // Inputs are set just after a falling edge; comb outputs checked, then registered outputs after the rise.
  task automatic step();
    int         need;
    bit         exp_stall, cond, exp_br;
    logic [5:0] op;
    #1;
    op        = instruction[31:26];
    need      = bubbles_needed(instruction, instr_valid);
    exp_stall = hazard_detected_in || owed > 0 || need > 0;
    cond      = (op == OP_JMP) || (op == OP_BEZ && rs_value == 0) ||
                (op == OP_BNE && rs_value != rt_value);
    exp_br    = cond && instr_valid && !exp_stall && !freeze;
    check("stall_out", stall_out, exp_stall);
    check("branch_taken", branch_taken, exp_br);
    check("rs", rs, instruction[25:21]);
    check("rt", rt, instruction[20:16]);
    obs_stall  = stall_out;
    obs_branch = branch_taken;
    if (rst) begin
      m_ex = '{default: 0};
      owed = 0;
    end else if (!freeze) begin
      m_ex = exp_stall ? '{default: 0} : model_issue(instruction, instr_valid, rs_value, rt_value);
      if (owed > 0)      owed--;
      else if (need > 0) owed = need - 1;
    end
    @(posedge clk);
    #1;
    check_ex();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input int s, input int t, input int imm);
    return {op, 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] op, input int s, input int t, input int d);
    return {op, 5'(s), 5'(t), 5'(d), 11'd0};
  endfunction

  task automatic set(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    instruction = ins; rs_value = a; rt_value = b;
    instr_valid = 1'b1; freeze = 1'b0; hazard_detected_in = 1'b0; rst = 1'b0;
  endtask

  logic [5:0] ops [8] = '{OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_BEZ, OP_BNE, OP_JMP, 6'd7};

  initial begin
    m_ex = '{default: 0};
    owed = 0;
    set(32'd0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    check("reset_ex_valid", ex_valid, 1'b0);

    // ADDI r2,r1,5
    set(mk_i(OP_ADDI, 1, 2, 5), 32'd10, 32'd0);
    step();
    check("addi_in1", ex_alu_in1, 32'd10);
    check("addi_in2", ex_alu_in2, 32'd5);
    check("addi_dest", ex_dest, 5'd2);
    check("addi_wb", ex_wb_en, 1'b1);
    check("addi_valid", ex_valid, 1'b1);

    // LD r3 then ADD r4,r3,r1
    set(mk_i(OP_LD, 1, 3, 4), 32'd100, 32'd0);
    step();
    set(mk_r(OP_ADD, 3, 1, 4), 32'd1, 32'd2);
    step();
`ifdef ID_HAZARD_UNIT_EN
    check("lduse_stall", obs_stall, 1'b1);
    check("lduse_bubble", ex_valid, 1'b0);
`endif
    step();
    check("lduse_issue_stall", obs_stall, 1'b0);
    check("lduse_issue_dest", ex_dest, 5'd4);

    // LD r5 then BEZ r5 with rs_value=0
    set(mk_i(OP_LD, 0, 5, 0), 32'd0, 32'd0);
    step();
    set(mk_i(OP_BEZ, 5, 0, 8), 32'd0, 32'd0);
    step();
`ifdef ID_HAZARD_UNIT_EN
    check("ldbr_stall1", obs_stall, 1'b1);
    step();
    check("ldbr_stall2", obs_stall, 1'b1);
    check("ldbr_bubble2", ex_valid, 1'b0);
    step();
    check("ldbr_resolve_stall", obs_stall, 1'b0);
`endif
    check("ldbr_taken", obs_branch, 1'b1);

    // BNE r1,r2 without hazard
    set(mk_i(OP_BNE, 1, 2, 3), 32'd7, 32'd9);
    step();
    check("bne_ne_taken", obs_branch, 1'b1);
    set(mk_i(OP_BNE, 1, 2, 3), 32'd7, 32'd7);
    step();
    check("bne_eq_taken", obs_branch, 1'b0);

    // Freeze while a bubble is still owed
    set(mk_i(OP_LD, 0, 5, 0), 32'd0, 32'd0);
    step();
    set(mk_i(OP_BEZ, 5, 0, 8), 32'd0, 32'd0);
    step();
    freeze = 1'b1;
    step();
    freeze = 1'b0;
    step();
    step();
    check("frz_resume_taken", obs_branch, 1'b1);

    // Reset in the middle of a two-bubble stall
    set(mk_i(OP_LD, 0, 5, 0), 32'd0, 32'd0);
    step();
    set(mk_i(OP_BEZ, 5, 0, 8), 32'd0, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("rst_mid_valid", ex_valid, 1'b0);
    rst = 1'b0;
    step();
    check("rst_mid_stall", obs_stall, 1'b0);
    check("rst_mid_taken", obs_branch, 1'b1);

    // Randomised traffic: small register range to provoke hazards, IF/ID held while stalled
    for (int i = 0; i < 1500; i++) begin
      if (!(obs_stall || freeze)) begin
        instruction = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 11'($urandom)};
        instr_valid = ($urandom_range(0, 9) != 0);
      end
      rs_value           = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rt_value           = ($urandom_range(0, 1) == 0) ? rs_value : $urandom;
      freeze             = ($urandom_range(0, 9) == 0);
      hazard_detected_in = ($urandom_range(0, 19) == 0);
      rst                = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_hazard.md
# id_stage_hazard

Parametrised decode stage with an integrated ID/EXE pipeline register and load/branch hazard sequencing. Decodes one instruction per cycle, resolves branches in ID, registers control and operands toward EXE, and inserts 1–2 bubbles via a stall counter when a source depends on an in-flight producer. Sits between the IF/ID register and the EXE stage; drives `stall_out` back to PC and IF/ID.

## Interface
- `WORD_LEN`, 32, datapath width
- `REG_ADDR_LEN`, 5, register address width
- `EXE_CMD_LEN`, 4, ALU command width
- `clk` in 1, single clock
- `rst` in 1, synchronous, active-high reset
- `instruction` in WORD_LEN, from IF/ID
- `instr_valid` in 1, IF/ID holds a real instruction
- `rs_value`, `rt_value` in WORD_LEN, register-file values after the external MEM/WB forwarding mux
- `hazard_detected_in` in 1, external bubble request
- `freeze` in 1, global hold (memory wait)
- `rs`, `rt` out REG_ADDR_LEN, comb, `instruction[25:21]`, `[20:16]`
- `branch_taken` out 1, comb, to IF
- `stall_out` out 1, comb, hold PC and IF/ID
- `ex_valid`, `ex_wb_en`, `ex_mem_read_en`, `ex_mem_write_en`, `ex_is_imm` out 1, registered
- `ex_exe_cmd` out EXE_CMD_LEN, registered
- `ex_alu_in1`, `ex_alu_in2`, `ex_st_value` out WORD_LEN, registered
- `ex_dest`, `ex_rs`, `ex_rt` out REG_ADDR_LEN, registered

## Operation
- Decode: opcode `[31:26]` maps to exe_cmd/wb/mem/is_imm/branch class through the shared table; unknown opcode decodes as NOP (all enables 0).
- Operands: `alu_in1` = rs_value; `alu_in2` = is_imm ? sign-extended `[15:0]` : rt_value; `st_value` = rt_value.
- Dest: is_imm ? `[20:16]` : `[15:11]`; ST and branches force wb_en=0.
- Uses-Rt: R-type, ST, BNE. Uses-Rs: all except JMP and NOP.
- Branches: BEZ taken if rs_value==0; BNE if rs_value!=rt_value; JMP always. `branch_taken` = cond & instr_valid & ~stall_out & ~freeze.
- Hazard (dest≠0, ID/EXE ex_valid=1, match on a used source): load-use non-branch → 1 bubble; branch on ALU producer → 1 bubble; branch on load → 2 bubbles.
- Stall counter `stall_cnt` (2 bit): IDLE (0) → loads 1 or 2 on detection; decrements each unfrozen cycle. `stall_out` = detection | stall_cnt>1 | hazard_detected_in. Counter only reloads from IDLE.
- Bubble: ID/EXE loads ex_valid=0, all enables 0, data fields 0.
- Register update priority: rst > freeze (hold all, counter holds) > bubble > load decoded instruction (ex_valid = instr_valid).

## Timing
- Reset: every `ex_*` output 0, stall_cnt 0; comb outputs follow inputs.
- Latency: instruction at cycle N appears on `ex_*` at N+1.
- Branch decision same cycle as decode; target arithmetic external.
- Load in EXE + dependent branch in ID: bubbles at N+1, N+2; branch resolves in N+2 using WB-forwarded value.
- `freeze` and hazard together: freeze wins; detection re-evaluated after release.
- `rst` mid-stall: counter cleared, no residual bubble.

## Configuration
- `ID_HAZARD_UNIT_EN` defined: internal detection and stall counter as above, OR'd with `hazard_detected_in`.
- Undefined: no internal detection, no counter; `stall_out` = `hazard_detected_in`, which inserts exactly one bubble per asserted cycle.

## Structure
- Shared package `id_pkg`: opcode constants (ADD 6'd1, ADDI 6'd32, LD 6'd36, ST 6'd37, BEZ 6'd40, BNE 6'd41, JMP 6'd42), EXE_CMD encodings, branch-class enum.
- Sub-module `id_decoder`: purely combinational opcode→control table; hazard logic, counter and ID/EXE register in the top.

## Test plan
- Reset then ADDI r2,r1,5 with rs_value=10 → next cycle ex_alu_in1=10, ex_alu_in2=5, ex_dest=2, ex_wb_en=1, ex_valid=1.
- LD r3 then ADD r4,r3,r1 → stall_out=1 one cycle, one bubble (ex_valid=0), ADD issues next cycle.
- LD r5 then BEZ r5 (`ID_HAZARD_UNIT_EN`) → stall_out high two cycles, two bubbles, then branch_taken if rs_value=0.
- BNE r1,r2 with 7/9, no hazard → branch_taken=1 same cycle; with 7/7 → 0.
- freeze=1 during a pending bubble → all ex_* hold, stall_cnt holds; resumes correctly on release.
- rst asserted at stall_cnt=2 → next cycle all ex_* 0, stall_out follows only current inputs.
